// File: rtl/core_pkg.sv
// Shared constants for the inter-core partial-sum exchange FIFO.
package core_pkg;

  localparam int unsigned BW_PSUM_DEF   = 20;
  // Stored word carries four guard bits above the raw psum.
  localparam int unsigned SUM_W         = BW_PSUM_DEF + 4;
  localparam int unsigned DEPTH_LOG_DEF = 2;
  // Extra MSB on each pointer distinguishes full from empty.
  localparam int unsigned PTR_W         = DEPTH_LOG_DEF + 1;

  typedef logic [SUM_W-1:0] sum_t;

endpackage

// File: rtl/xfifo_ptr.sv
// Wrapping FIFO pointer: synchronous clear, increment enable, async active-high reset.
module xfifo_ptr
  import core_pkg::*;
#(
  parameter int unsigned W = PTR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] PtrOne = W'(1);

  logic [W-1:0] r_ptr;

  // Pointer register; wraps naturally modulo 2**W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (clr) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= r_ptr + PtrOne;
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/core_sum_xfifo.sv
// Inter-core partial-sum exchange buffer: first-word-fall-through FIFO with
// occupancy count, full flag and sticky overflow/underflow flags.
// Optional high-water-mark output enabled by defining CORE_SUM_XFIFO_HWM_EN.
module core_sum_xfifo
  import core_pkg::*;
#(
  parameter int unsigned bw_psum   = BW_PSUM_DEF,
  parameter int unsigned depth_log = DEPTH_LOG_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   wr,
  input  logic [bw_psum+3:0]     sum_in,
  output logic                   full,
  input  logic                   rd,
  output logic [bw_psum+3:0]     sum_out,
  output logic                   sum_out_vld,
  output logic [depth_log:0]     count,
`ifdef CORE_SUM_XFIFO_HWM_EN
  output logic [depth_log:0]     hwm,
`endif
  output logic                   ovf_err,
  output logic                   udf_err
);

  localparam int unsigned WordW = bw_psum + 4;
  localparam int unsigned Depth = 2 ** depth_log;
  localparam int unsigned PtrW  = depth_log + 1;
  localparam logic [PtrW-1:0] CntOne = PtrW'(1);

  logic [WordW-1:0] r_mem [Depth];
  logic [PtrW-1:0]  w_wr_ptr;
  logic [PtrW-1:0]  w_rd_ptr;
  logic [PtrW-1:0]  r_count;
  logic [PtrW-1:0]  w_count_nxt;
  logic             r_ovf;
  logic             r_udf;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_empty = (w_wr_ptr == w_rd_ptr);
  assign w_full  = (w_wr_ptr[depth_log-1:0] == w_rd_ptr[depth_log-1:0]) &&
                   (w_wr_ptr[depth_log] != w_rd_ptr[depth_log]);

  // A pop while full frees the slot the push needs; a pop while empty never proceeds.
  assign w_push = wr && (!w_full || rd) && !clr;
  assign w_pop  = rd && !w_empty && !clr;

  xfifo_ptr #(
    .W (PtrW)
  ) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (w_push),
    .ptr   (w_wr_ptr)
  );

  xfifo_ptr #(
    .W (PtrW)
  ) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (w_pop),
    .ptr   (w_rd_ptr)
  );

  // Storage write; data is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_ptr[depth_log-1:0]] <= sum_in;
    end
  end

  // Next occupancy: up on push-only, down on pop-only, cleared by clr.
  always_comb begin
    w_count_nxt = r_count;
    if (clr) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CntOne;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CntOne;
    end
  end

  // Count and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (clr) begin
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
      end else begin
        if (wr && w_full && !rd) r_ovf <= 1'b1;
        if (rd && w_empty)       r_udf <= 1'b1;
      end
    end
  end

`ifdef CORE_SUM_XFIFO_HWM_EN
  logic [PtrW-1:0] r_hwm;

  // High-water mark tracks the peak of next-state occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hwm <= '0;
    end else if (clr) begin
      r_hwm <= '0;
    end else if (w_count_nxt > r_hwm) begin
      r_hwm <= w_count_nxt;
    end
  end

  assign hwm = r_hwm;
`endif

  assign sum_out     = r_mem[w_rd_ptr[depth_log-1:0]];
  assign sum_out_vld = !w_empty;
  assign full        = w_full;
  assign count       = r_count;
  assign ovf_err     = r_ovf;
  assign udf_err     = r_udf;

endmodule

// File: tb/tb_core_sum_xfifo.sv
// Directed self-checking bench for core_sum_xfifo (4-entry default build).
// hwm checks are included when CORE_SUM_XFIFO_HWM_EN is defined.
module tb_core_sum_xfifo;

  localparam int unsigned BwPsum   = 20;
  localparam int unsigned DepthLog = 2;

  logic                 clk;
  logic                 reset;
  logic                 clr;
  logic                 wr;
  logic                 rd;
  logic [BwPsum+3:0]    sum_in;
  logic                 full;
  logic [BwPsum+3:0]    sum_out;
  logic                 sum_out_vld;
  logic [DepthLog:0]    count;
  logic                 ovf_err;
  logic                 udf_err;
`ifdef CORE_SUM_XFIFO_HWM_EN
  logic [DepthLog:0]    hwm;
`endif

  int n_cmp;
  int n_bad;

  core_sum_xfifo #(
    .bw_psum   (BwPsum),
    .depth_log (DepthLog)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clr         (clr),
    .wr          (wr),
    .sum_in      (sum_in),
    .full        (full),
    .rd          (rd),
    .sum_out     (sum_out),
    .sum_out_vld (sum_out_vld),
    .count       (count),
`ifdef CORE_SUM_XFIFO_HWM_EN
    .hwm         (hwm),
`endif
    .ovf_err     (ovf_err),
    .udf_err     (udf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    wr     = 1'b1;
    sum_in = v[BwPsum+3:0];
    tick();
    wr     = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp);
    chk({tag, "_vld"}, 32'(sum_out_vld), 32'd1);
    chk({tag, "_dat"}, 32'(sum_out), exp);
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    reset  = 1'b1;
    clr    = 1'b0;
    wr     = 1'b0;
    rd     = 1'b0;
    sum_in = '0;
    #1;
    chk("rst_vld",   32'(sum_out_vld), 32'd0);
    chk("rst_count", 32'(count),       32'd0);
    chk("rst_full",  32'(full),        32'd0);
    chk("rst_ovf",   32'(ovf_err),     32'd0);
    chk("rst_udf",   32'(udf_err),     32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Single word: latency 1, then pop empties.
    push(32'h00000A);
    chk("t1_vld",   32'(sum_out_vld), 32'd1);
    chk("t1_dat",   32'(sum_out),     32'h00000A);
    chk("t1_count", 32'(count),       32'd1);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("t1_vld0",   32'(sum_out_vld), 32'd0);
    chk("t1_count0", 32'(count),       32'd0);

    // Fill, overflow, drain in order.
    for (int i = 1; i <= 4; i++) push(32'(i));
    chk("t2_full",  32'(full),  32'd1);
    chk("t2_count", 32'(count), 32'd4);
    push(32'h000005);
    chk("t2_ovf",    32'(ovf_err), 32'd1);
    chk("t2_count5", 32'(count),   32'd4);
    chk("t2_full5",  32'(full),    32'd1);
    for (int i = 1; i <= 4; i++) pop_chk("t2_pop", 32'(i));
    chk("t2_empty",  32'(sum_out_vld), 32'd0);
    chk("t2_ovf_sticky", 32'(ovf_err), 32'd1);
    do_clr();
    chk("t2_ovf_clr", 32'(ovf_err), 32'd0);

    // Full with simultaneous push and pop.
    for (int i = 1; i <= 4; i++) push(32'(i));
    wr = 1'b1;
    rd = 1'b1;
    sum_in = 24'h0000AA;
    tick();
    wr = 1'b0;
    rd = 1'b0;
    chk("t3_count", 32'(count),   32'd4);
    chk("t3_full",  32'(full),    32'd1);
    chk("t3_ovf",   32'(ovf_err), 32'd0);
    pop_chk("t3_pop", 32'h2);
    pop_chk("t3_pop", 32'h3);
    pop_chk("t3_pop", 32'h4);
    pop_chk("t3_pop", 32'hAA);
    chk("t3_count0", 32'(count), 32'd0);

    // Underflow, then clr wins over a push.
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("t4_udf",   32'(udf_err), 32'd1);
    chk("t4_count", 32'(count),   32'd0);
    clr = 1'b1;
    wr  = 1'b1;
    sum_in = 24'h000055;
    tick();
    clr = 1'b0;
    wr  = 1'b0;
    chk("t4_udf_clr", 32'(udf_err),     32'd0);
    chk("t4_count_c", 32'(count),       32'd0);
    chk("t4_vld_c",   32'(sum_out_vld), 32'd0);

    // Push and pop together on an empty FIFO: push only, underflow flagged.
    wr = 1'b1;
    rd = 1'b1;
    sum_in = 24'h000077;
    tick();
    wr = 1'b0;
    rd = 1'b0;
    chk("t4b_count", 32'(count),   32'd1);
    chk("t4b_udf",   32'(udf_err), 32'd1);
    pop_chk("t4b_pop", 32'h77);
    do_clr();

    // Ten words streamed through with one in flight; pointers wrap.
    push(32'h100);
    for (int i = 1; i <= 9; i++) begin
      chk("t5_dat", 32'(sum_out), 32'h100 + 32'(i) - 32'd1);
      wr = 1'b1;
      rd = 1'b1;
      sum_in = 24'(32'h100 + 32'(i));
      tick();
      chk("t5_count", 32'(count), 32'd1);
    end
    wr = 1'b0;
    rd = 1'b0;
    pop_chk("t5_last", 32'h109);
    chk("t5_count0", 32'(count), 32'd0);

    // Asynchronous reset mid-transfer.
    push(32'h0000C1);
    push(32'h0000C2);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_count", 32'(count),       32'd0);
    chk("t6_vld",   32'(sum_out_vld), 32'd0);
    tick();
    reset = 1'b0;
    tick();

`ifdef CORE_SUM_XFIFO_HWM_EN
    for (int i = 1; i <= 3; i++) push(32'(i));
    for (int i = 1; i <= 3; i++) pop_chk("t7_pop", 32'(i));
    chk("t7_hwm", 32'(hwm), 32'd3);
    do_clr();
    chk("t7_hwm_clr", 32'(hwm), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_sum_xfifo.md
Name: core_sum_xfifo

Overview:
- Inter-core partial-sum exchange buffer; sits directly downstream of the sfp_row sum output in each core.
- Buffers locally produced row sums (width bw_psum+4) until the peer core pops them.
- Drives the peer-facing sum_out / sum_out_vld pair; the peer's fifo_ext_rd pops it.
- First-word-fall-through FIFO with occupancy count, full flag and sticky error flags.

Parameters:
- bw_psum, 20, psum width; stored word width is bw_psum+4.
- depth_log, 2, log2 of FIFO depth; depth = 2**depth_log (default 4 entries).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous flush of pointers, count and error flags.
- wr  input  1  push request from local sfp_row.
- sum_in  input  bw_psum+4  word to push.
- full  output  1  FIFO holds depth words.
- rd  input  1  pop request; driven by the peer core's fifo_ext_rd.
- sum_out  output  bw_psum+4  head word, valid when sum_out_vld=1.
- sum_out_vld  output  1  FIFO not empty.
- count  output  depth_log+1  current occupancy, 0..depth.
- ovf_err  output  1  sticky: push attempted while full with no pop in the same cycle.
- udf_err  output  1  sticky: pop attempted while empty.

Behaviour:
- Storage: depth x (bw_psum+4) register array, no reset on data.
- Pointers: wr_ptr and rd_ptr, each depth_log+1 bits.
  - Index uses the low depth_log bits; the MSB is the wrap bit.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
- Reset (asynchronous): pointers=0, count=0, ovf_err=0, udf_err=0, so full=0 and sum_out_vld=0.
- sum_out = mem[rd_ptr index], combinational from registers (FWFT).
  - Its value is don't-care while sum_out_vld=0; the bench checks it only when sum_out_vld=1.
- Push:
  - Takes effect when wr=1 and (not full, or rd=1 while full).
  - Writes mem[wr_ptr], then wr_ptr increments.
  - A word pushed into an empty FIFO appears on sum_out with sum_out_vld=1 the next cycle (latency 1).
- Pop:
  - Takes effect when rd=1 and not empty; rd_ptr increments.
  - The next head word is visible the following cycle.
- Same-cycle wr and rd:
  - Empty: push proceeds, pop ignored, udf_err set; count becomes 1.
  - Full: both proceed; count stays at depth, full stays 1, no ovf_err.
  - Otherwise: both proceed; count unchanged.
- Overflow: wr=1 while full and rd=0 drops the word, state is unchanged, and ovf_err sets to 1 and holds.
- Underflow: rd=1 while empty leaves state unchanged and sets udf_err to 1, which holds.
- Pointer wrap: natural modulo-2**(depth_log+1) increment; no special case.
- count: registered; increments on push-only, decrements on pop-only, holds otherwise.
- clr:
  - Has priority over wr and rd in the same cycle; both requests are ignored.
  - Zeroes pointers, count and both error flags.
  - Storage contents are left as-is.
- Reset asserted mid-transfer: everything returns to reset values immediately; in-flight words are lost.

Optional Feature:
- Macro: CORE_SUM_XFIFO_HWM_EN.
- Defined:
  - Adds output port hwm (depth_log+1 bits): the high-water mark of count since the last reset or clr.
  - Updated each cycle as max(hwm, next count).
  - Cleared by reset and by clr.
- Undefined: the hwm port and its register do not exist; all other behaviour is identical.

Decomposition:
- Shared package core_pkg holds:
  - constant SUM_W = bw_psum+4 (default 24);
  - default depth_log = 2;
  - pointer-width helper constant PTR_W = depth_log+1.
- One sub-module: xfifo_ptr, holding a pointer register with increment enable and clear, instantiated twice (write and read).
- Flags and count logic stay in the top module.

Test Plan:
- Reset, then push 0x00000A: the next cycle shows sum_out_vld=1, sum_out=0x00000A, count=1; rd=1 one cycle then gives sum_out_vld=0, count=0.
- Push 0x000001..0x000004 on consecutive cycles: full=1, count=4. A fifth push (0x000005) with rd=0 gives ovf_err=1, count=4, and pops return 1,2,3,4 in order.
- FIFO full plus simultaneous wr=1 (0x0000AA) and rd=1: 0x000001 popped, count stays 4, ovf_err stays 0. Draining yields 2,3,4,0xAA.
- Empty FIFO with rd=1 gives udf_err=1, count=0. Then clr=1 with wr=1 gives udf_err=0, count=0, and the word is not stored.
- Run 10 push/pop pairs through the 4-entry FIFO, exercising pointer wrap twice: output order matches input order and count returns to 0.
- With CORE_SUM_XFIFO_HWM_EN, push 3 words then pop all: hwm=3. After clr, hwm=0.
